// File: rtl/vector_reduce_accumulator.sv
// Multi-beat vector reduction: folds masked DATA_WIDTH-bit beats elementwise, then
// halves the accumulator down to one element and combines it with a scalar init operand.
module vector_reduce_accumulator #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic [DATA_WIDTH/8-1:0]   req_mask,
    input  logic                      req_last,
    input  logic [2:0]                req_opcode,
    input  logic [1:0]                req_vsew,
    input  logic                      req_sign,
    input  logic [31:0]               req_init,
    input  logic                      flush,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_data
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int HW = $clog2(DATA_WIDTH) + 1;

    localparam logic [2:0] sIdle  = 3'd0;
    localparam logic [2:0] sAccum = 3'd1;
    localparam logic [2:0] sFold  = 3'd2;
    localparam logic [2:0] sFinal = 3'd3;
    localparam logic [2:0] sResp  = 3'd4;

    localparam logic [2:0] opSum = 3'd0;
    localparam logic [2:0] opMin = 3'd1;
    localparam logic [2:0] opMax = 3'd2;
    localparam logic [2:0] opAnd = 3'd3;
    localparam logic [2:0] opOr  = 3'd4;
    localparam logic [2:0] opXor = 3'd5;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] acc;
    logic [HW-1:0]         halfW;
    logic [2:0]            cOp;
    logic [1:0]            cSew;
    logic                  cSign;
    logic [31:0]           cInit;
    logic [31:0]           respData;
    logic                  accept;

    function automatic logic [2:0] opNorm(input logic [2:0] op);
        return (op > opXor) ? opSum : op;
    endfunction

    function automatic logic [1:0] sewNorm(input logic [1:0] sew);
        return (sew == 2'd3) ? 2'd2 : sew;
    endfunction

    function automatic logic [HW-1:0] ewOf(input logic [1:0] sew);
        case (sew)
            2'd0:    return HW'(8);
            2'd1:    return HW'(16);
            default: return HW'(32);
        endcase
    endfunction

    function automatic logic [31:0] ewMask(input logic [1:0] sew);
        case (sew)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Single element op at width 8<<sew; inputs are taken from the low bits.
    function automatic logic [31:0] elemOp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic sgn,
                                           input logic [1:0] sew);
        logic [31:0] m, aM, bM, r;
        logic [32:0] aX, bX;
        logic        aNeg, bNeg, bLt, bGt;
        m  = ewMask(sew);
        aM = a & m;
        bM = b & m;
        case (sew)
            2'd0:    begin aNeg = sgn & a[7];  bNeg = sgn & b[7];  end
            2'd1:    begin aNeg = sgn & a[15]; bNeg = sgn & b[15]; end
            default: begin aNeg = sgn & a[31]; bNeg = sgn & b[31]; end
        endcase
        aX  = {1'b0, aM} | (aNeg ? {1'b1, ~m} : 33'd0);
        bX  = {1'b0, bM} | (bNeg ? {1'b1, ~m} : 33'd0);
        bLt = $signed(bX) < $signed(aX);
        bGt = $signed(bX) > $signed(aX);
        case (op)
            opMin:   r = bLt ? bM : aM;
            opMax:   r = bGt ? bM : aM;
            opAnd:   r = aM & bM;
            opOr:    r = aM | bM;
            opXor:   r = aM ^ bM;
            default: r = aM + bM;
        endcase
        return r & m;
    endfunction

    function automatic logic [31:0] identity(input logic [2:0] op, input logic sgn,
                                             input logic [1:0] sew);
        logic [31:0] m;
        m = ewMask(sew);
        case (op)
            opAnd:   return m;
            opMin:   return sgn ? (m >> 1) : m;
            opMax:   return sgn ? (m ^ (m >> 1)) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] vecOp(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b,
                                                    input logic [2:0] op, input logic sgn,
                                                    input logic [1:0] sew);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (sew)
            2'd0: for (int e = 0; e < DATA_WIDTH/8; e++)
                r[e*8 +: 8] = 8'(elemOp({24'd0, a[e*8 +: 8]}, {24'd0, b[e*8 +: 8]}, op, sgn, sew));
            2'd1: for (int e = 0; e < DATA_WIDTH/16; e++)
                r[e*16 +: 16] = 16'(elemOp({16'd0, a[e*16 +: 16]}, {16'd0, b[e*16 +: 16]}, op, sgn, sew));
            default: for (int e = 0; e < DATA_WIDTH/32; e++)
                r[e*32 +: 32] = elemOp(a[e*32 +: 32], b[e*32 +: 32], op, sgn, sew);
        endcase
        return r;
    endfunction

    // Inactive elements become the op identity so they drop out of the reduction.
    function automatic logic [DATA_WIDTH-1:0] maskBeat(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [MASK_WIDTH-1:0] mask,
                                                       input logic [2:0] op, input logic sgn,
                                                       input logic [1:0] sew);
        logic [DATA_WIDTH-1:0] r;
        logic [31:0]           idn;
        r   = d;
        idn = identity(op, sgn, sew);
        case (sew)
            2'd0: for (int e = 0; e < DATA_WIDTH/8; e++)
                if (!mask[e]) r[e*8 +: 8] = idn[7:0];
            2'd1: for (int e = 0; e < DATA_WIDTH/16; e++)
                if (!mask[e*2]) r[e*16 +: 16] = idn[15:0];
            default: for (int e = 0; e < DATA_WIDTH/32; e++)
                if (!mask[e*4]) r[e*32 +: 32] = idn;
        endcase
        return r;
    endfunction

    assign req_ready  = !reset && (state == sIdle || state == sAccum);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == sResp);
    assign resp_data  = respData;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= sIdle;
            acc      <= '0;
            halfW    <= '0;
            cOp      <= '0;
            cSew     <= '0;
            cSign    <= 1'b0;
            cInit    <= '0;
            respData <= '0;
        end else if (flush) begin
            state <= sIdle;
        end else begin
            case (state)
                sIdle: if (accept) begin
                    cOp   <= opNorm(req_opcode);
                    cSew  <= sewNorm(req_vsew);
                    cSign <= req_sign;
                    cInit <= req_init;
                    acc   <= maskBeat(req_data, req_mask, opNorm(req_opcode), req_sign,
                                      sewNorm(req_vsew));
                    halfW <= HW'(DATA_WIDTH/2);
                    if (req_last)
                        state <= (HW'(DATA_WIDTH) == ewOf(sewNorm(req_vsew))) ? sFinal : sFold;
                    else
                        state <= sAccum;
                end
                sAccum: if (accept) begin
                    acc   <= vecOp(acc, maskBeat(req_data, req_mask, cOp, cSign, cSew),
                                   cOp, cSign, cSew);
                    halfW <= HW'(DATA_WIDTH/2);
                    if (req_last)
                        state <= (HW'(DATA_WIDTH) == ewOf(cSew)) ? sFinal : sFold;
                end
                sFold: begin
                    // Only the low halfW bits stay meaningful; upper bits are don't-care.
                    acc <= vecOp(acc, acc >> halfW, cOp, cSign, cSew);
                    if (halfW == ewOf(cSew)) state <= sFinal;
                    else                     halfW <= halfW >> 1;
                end
                sFinal: begin
                    respData <= elemOp(acc[31:0], cInit, cOp, cSign, cSew);
                    state    <= sResp;
                end
                sResp: if (resp_ready) state <= sIdle;
                default: state <= sIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_reduce_accumulator.sv
// Directed bench for vector_reduce_accumulator with hand-computed expected results.
module tb_vector_reduce_accumulator;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_last, req_sign, flush;
    logic [63:0] req_data;
    logic [7:0]  req_mask;
    logic [2:0]  req_opcode;
    logic [1:0]  req_vsew;
    logic [31:0] req_init;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;

    int errors = 0;
    int checks = 0;

    vector_reduce_accumulator #(.DATA_WIDTH(64)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_mask(req_mask), .req_last(req_last), .req_opcode(req_opcode),
        .req_vsew(req_vsew), .req_sign(req_sign), .req_init(req_init),
        .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; presents one beat and returns just after its acceptance edge.
    task automatic beat(input logic [63:0] d, input logic [7:0] m, input logic l,
                        input logic [2:0] op, input logic [1:0] sew, input logic sg,
                        input logic [31:0] ini);
        req_valid = 1'b1; req_data = d; req_mask = m; req_last = l;
        req_opcode = op; req_vsew = sew; req_sign = sg; req_init = ini;
        @(posedge clock); #1;
        req_valid = 1'b0; req_last = 1'b0;
    endtask

    task automatic waitResp(input string tag, input int expLat, input logic [31:0] expData);
        int cnt = 0;
        while (!resp_valid && cnt < 20) begin
            @(posedge clock); #1;
            cnt++;
        end
        chk({tag, "_lat"}, cnt, expLat);
        chk({tag, "_data"}, resp_data, expData);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_last = 1'b0; req_sign = 1'b0; flush = 1'b0;
        req_data = '0; req_mask = '0; req_opcode = '0; req_vsew = '0; req_init = '0;
        resp_ready = 1'b0;
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_data", resp_data, 32'd0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        beat(64'h0102030405060708, 8'hFF, 1'b1, 3'd0, 2'd0, 1'b0, 32'h10);
        waitResp("sum8", 4, 32'h34);

        beat(64'h7FFF000180000002, 8'hFF, 1'b0, 3'd2, 2'd1, 1'b1, 32'h0);
        beat(64'h0003FFFF00040005, 8'hFF, 1'b1, 3'd0, 2'd0, 1'b0, 32'hFFFF);
        waitResp("maxs16", 3, 32'h7FFF);
        beat(64'h7FFF000180000002, 8'hFF, 1'b0, 3'd1, 2'd1, 1'b1, 32'h0);
        beat(64'h0003FFFF00040005, 8'hFF, 1'b1, 3'd2, 2'd1, 1'b0, 32'h0);
        waitResp("mins16", 3, 32'h8000);
        beat(64'h7FFF000180000002, 8'hFF, 1'b0, 3'd2, 2'd1, 1'b0, 32'h0);
        beat(64'h0003FFFF00040005, 8'hFF, 1'b1, 3'd2, 2'd1, 1'b1, 32'h0);
        waitResp("maxu16", 3, 32'hFFFF);

        beat(64'h0000000500000003, 8'h0F, 1'b1, 3'd0, 2'd2, 1'b0, 32'h1);
        waitResp("sum32m", 2, 32'h4);
        beat(64'h0000000500000003, 8'h00, 1'b1, 3'd3, 2'd3, 1'b0, 32'hF0F0F0F0);
        waitResp("and32", 2, 32'hF0F0F0F0);

        beat(64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 3'd0, 2'd0, 1'b0, 32'hFFFF_FF08);
        waitResp("wrap8", 4, 32'h0);

        beat(64'h0102030405060708, 8'hFF, 1'b1, 3'd5, 2'd0, 1'b0, 32'h0F);
        waitResp("xor8", 4, 32'h07);
        beat(64'h0102030405060708, 8'h7F, 1'b1, 3'd1, 2'd0, 1'b0, 32'hFF);
        waitResp("minu8m", 4, 32'h02);
        beat(64'h7FFF000180000002, 8'h33, 1'b1, 3'd1, 2'd1, 1'b1, 32'h5);
        waitResp("mins16m", 3, 32'h1);
        beat(64'h0000000500000003, 8'hFF, 1'b1, 3'd6, 2'd2, 1'b0, 32'h2);
        waitResp("op6sum", 2, 32'hA);
        beat(64'h00000000000000F0, 8'hFF, 1'b1, 3'd4, 2'd0, 1'b0, 32'h0F);
        waitResp("or8", 4, 32'hFF);

        // Backpressure: hold the response for three cycles.
        beat(64'h0102030405060708, 8'hFF, 1'b1, 3'd0, 2'd0, 1'b0, 32'h10);
        for (int i = 0; i < 4; i++) begin @(posedge clock); #1; end
        chk("bp_valid", {31'd0, resp_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("bp_data", resp_data, 32'h34);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk("bp_valid_low", {31'd0, resp_valid}, 32'd0);
        chk("bp_ready_high", {31'd0, req_ready}, 32'd1);

        // Flush in ACCUM, concurrent with a last beat that must be dropped.
        beat(64'h1, 8'hFF, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
        beat(64'h2, 8'hFF, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
        flush = 1'b1; req_valid = 1'b1; req_last = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; req_valid = 1'b0; req_last = 1'b0;
        chk("flush_idle", {31'd0, req_ready}, 32'd1);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clock); #1;
                if (resp_valid) seen = 1'b1;
            end
            chk("flush_noresp", {31'd0, seen}, 32'd0);
        end
        beat(64'h0102030405060708, 8'hFF, 1'b1, 3'd0, 2'd0, 1'b0, 32'h0);
        waitResp("post_flush", 4, 32'h24);

        // Async reset while folding; resp_data is nonzero beforehand.
        beat(64'h0102030405060708, 8'hFF, 1'b1, 3'd0, 2'd0, 1'b0, 32'h10);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_data", resp_data, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        beat(64'h0003FFFF00040005, 8'hFF, 1'b1, 3'd2, 2'd1, 1'b1, 32'h0);
        waitResp("post_rst", 3, 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
